// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
// Holds the 4-bit ALU op codes, the legal-op check and the arbiter FSM state encoding.
package alu_pkg;

  // ALU op codes: {sub/arith modifier, function}.
  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b1000;
  localparam logic [3:0] OpSlt  = 4'b0010;
  localparam logic [3:0] OpSltu = 4'b0011;
  localparam logic [3:0] OpAnd  = 4'b0111;
  localparam logic [3:0] OpOr   = 4'b0110;
  localparam logic [3:0] OpXor  = 4'b0100;
  localparam logic [3:0] OpSll  = 4'b0001;
  localparam logic [3:0] OpSrl  = 4'b0101;
  localparam logic [3:0] OpSra  = 4'b1101;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OpAdd, OpSub, OpSlt, OpSltu, OpAnd,
      OpOr, OpXor, OpSll, OpSrl, OpSra: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between two requesters and the ALU arbiter.
// slave:  arbiter side (takes requests, produces responses).
// master: requester side (drives requests, consumes responses).
interface alu_arbiter_if;
  logic        req_valid_0;
  logic        req_valid_1;
  logic        req_ready_0;
  logic        req_ready_1;
  logic [31:0] req_a_0;
  logic [31:0] req_a_1;
  logic [31:0] req_b_0;
  logic [31:0] req_b_1;
  logic [3:0]  req_op_0;
  logic [3:0]  req_op_1;
  logic        rsp_valid_0;
  logic        rsp_valid_1;
  logic        rsp_ready_0;
  logic        rsp_ready_1;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  modport slave (
    input  req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
    input  req_op_0, req_op_1, rsp_ready_0, rsp_ready_1,
    output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_data, rsp_err, busy
  );

  modport master (
    output req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
    output req_op_0, req_op_1, rsp_ready_0, rsp_ready_1,
    input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/alu.sv
// Combinational 32-bit integer ALU.
// op_i: 5-bit op (bit 4 reserved, 0 for all supported ops); a_i/b_i: operands; y_o: result.
// Unsupported op codes produce 0.
module alu
  import alu_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    y_o = '0;
    case (op_i)
      {1'b0, OpAdd}:  y_o = a_i + b_i;
      {1'b0, OpSub}:  y_o = a_i - b_i;
      {1'b0, OpSlt}:  y_o = {31'b0, $signed(a_i) < $signed(b_i)};
      {1'b0, OpSltu}: y_o = {31'b0, a_i < b_i};
      {1'b0, OpAnd}:  y_o = a_i & b_i;
      {1'b0, OpOr}:   y_o = a_i | b_i;
      {1'b0, OpXor}:  y_o = a_i ^ b_i;
      {1'b0, OpSll}:  y_o = a_i << shamt;
      {1'b0, OpSrl}:  y_o = a_i >> shamt;
      {1'b0, OpSra}:  y_o = $signed(a_i) >>> shamt;
      default:        y_o = '0;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant.
// valid_i: request pair; prio_i: requester that wins a tie; gnt_o: one-hot grant (0 if no request).
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       prio_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    if (&valid_i) begin
      gnt_o = prio_i ? 2'b10 : 2'b01;
    end else begin
      gnt_o = valid_i;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters, one operation in flight at a time.
// clk/rst: clock and asynchronous active-high reset.
// bus: request handshake (valid/ready + a, b, op per requester) and response handshake
//      (valid/ready per requester, shared rsp_data/rsp_err), plus busy.
// Flow: IDLE accepts the granted request, EXEC registers the ALU result, RESP holds it
// until the granted requester takes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic        id_q, id_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic [1:0]  gnt;
  logic [31:0] alu_y;
  logic        op_legal;
  logic        rsp_ready_sel;

  rr_arb2 u_rr_arb2 (
    .valid_i ({bus.req_valid_1, bus.req_valid_0}),
    .prio_i  (prio_q),
    .gnt_o   (gnt)
  );

  alu u_alu (
    .op_i ({1'b0, op_q}),
    .a_i  (a_q),
    .b_i  (b_q),
    .y_o  (alu_y)
  );

  assign op_legal      = is_legal_op(op_q);
  // Only the granted requester's rsp_ready can complete the response.
  assign rsp_ready_sel = id_q ? bus.rsp_ready_1 : bus.rsp_ready_0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      prio_q     <= RR_INIT;
      id_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (|gnt) begin
          state_d = StExec;
          id_d    = gnt[1];
          // Priority passes to the requester that was not served.
          prio_d  = ~gnt[1];
          a_d     = gnt[1] ? bus.req_a_1  : bus.req_a_0;
          b_d     = gnt[1] ? bus.req_b_1  : bus.req_b_0;
          op_d    = gnt[1] ? bus.req_op_1 : bus.req_op_0;
        end
      end
      StExec: begin
        state_d    = StResp;
        rsp_data_d = op_legal ? alu_y : '0;
        rsp_err_d  = ~op_legal;
      end
      StResp: begin
        if (rsp_ready_sel) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.req_ready_0 = 1'b0;
    bus.req_ready_1 = 1'b0;
    bus.rsp_valid_0 = 1'b0;
    bus.rsp_valid_1 = 1'b0;
    if (state_q == StIdle) begin
      bus.req_ready_0 = gnt[0];
      bus.req_ready_1 = gnt[1];
    end
    if (state_q == StResp) begin
      bus.rsp_valid_0 = ~id_q;
      bus.rsp_valid_1 = id_q;
    end
    bus.rsp_data = rsp_data_q;
    bus.rsp_err  = rsp_err_q;
    bus.busy     = (state_q != StIdle);
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter RR_INIT, default 0, meaning the requester that holds priority after reset (0 or 1).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports req_valid_0 / req_valid_1  input  1  requester N presents an operation.
REQ-005 SHALL have ports req_ready_0 / req_ready_1  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 SHALL have ports req_a_0 / req_a_1, req_b_0 / req_b_1  input  32  operands.
REQ-007 SHALL have ports req_op_0 / req_op_1  input  4  ALU op code.
REQ-008 SHALL have ports rsp_valid_0 / rsp_valid_1  output  1  result available for requester N.
REQ-009 SHALL have ports rsp_ready_0 / rsp_ready_1  input  1  requester N consumes the result.
REQ-010 SHALL have port rsp_data  output  32  result, shared by both requesters, qualified by rsp_valid_N.
REQ-011 SHALL have port rsp_err  output  1  op code was illegal, qualified by rsp_valid_N.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC and RESP; one operation in flight at a time.
REQ-014 In IDLE with exactly one req_valid_N high, SHALL combinationally assert req_ready_N and latch a, b, op and the requester id at the clock edge, then go to EXEC.
REQ-015 In IDLE with both valid, SHALL grant the priority holder and assert req_ready only to it.
REQ-016 Priority SHALL pass to the non-granted requester on every accept; with no accept it SHALL hold.
REQ-017 req_ready_N SHALL be 0 in EXEC and RESP; a requester holding valid SHALL keep its inputs stable until accepted.
REQ-018 In EXEC, SHALL drive the shared alu with the latched operands, and register its output into rsp_data at the edge, then go to RESP.
REQ-019 Legal op codes SHALL be 0000, 1000, 0010, 0011, 0111, 0110, 0100, 0001, 0101 and 1101; the alu op port is 5 bits, with bit 4 tied to 0.
REQ-020 For an illegal op, SHALL register rsp_data = 0 and rsp_err = 1; otherwise rsp_err = 0.
REQ-021 In RESP, SHALL hold rsp_valid_N high for the granted requester only, with rsp_data and rsp_err stable, until rsp_ready_N is high; that cycle SHALL return to IDLE.
REQ-022 Latency SHALL be: accept at edge k, rsp_valid at cycle k+2; peak throughput is one op per 3 cycles.
REQ-023 rsp_ready of the non-granted requester SHALL be ignored; rsp_ready in IDLE or EXEC SHALL be ignored.
REQ-024 A request arriving during EXEC/RESP SHALL wait, and SHALL be arbitrated in the next IDLE cycle.
REQ-025 SLT/SLTU results SHALL be exactly 0 or 1 in bit 0, with bits 31:1 zero; shifts SHALL use b[4:0] only.

Reset
REQ-026 On rst, SHALL asynchronously force: state IDLE; priority RR_INIT; rsp_valid_0/1 = 0; rsp_data = 0; rsp_err = 0; busy = 0; latched operands and id = 0.
REQ-027 On rst mid-operation (EXEC or RESP), SHALL discard the in-flight operation and never deliver its response.
REQ-028 After rst deasserts, SHALL be able to accept in the first clock cycle.

Structure
REQ-029 Package alu_pkg SHALL hold the 4-bit op code constants, the legal-op check function and the FSM state encoding.
REQ-030 SHALL instantiate exactly one existing alu as the shared datapath.
REQ-031 The two-way round-robin grant logic SHALL be a sub-module rr_arb2 (inputs: valid pair and priority; outputs: one-hot grant).

Verification
REQ-032 After reset, with RR_INIT=0, req_valid_0 high, a=5, b=3, op=1000 -> req_ready_0 high in the same cycle, rsp_valid_0 two cycles later, rsp_data=2, rsp_err=0.
REQ-033 Both valid for 4 consecutive ops, rsp_ready tied high -> grants 0,1,0,1 and each rsp_data matches its own requester's operands.
REQ-034 a=0xFFFFFFFF, b=1, op=0010 -> rsp_data=1; same operands with op=0011 -> rsp_data=0; a=0x80000000, b=4, op=1101 -> rsp_data=0xF8000000.
REQ-035 op=1111 -> rsp_data=0 and rsp_err=1; the next legal op -> rsp_err=0.
REQ-036 rsp_ready_1 low for 5 cycles in RESP while req_valid_0 is high -> rsp_valid_1 and rsp_data stay stable, req_ready_0 stays 0, and req_valid_0 is accepted in the cycle after rsp_ready_1 goes high.
REQ-037 rst pulsed in EXEC -> no rsp_valid afterwards, busy=0, and priority returns to RR_INIT.
